// File: rtl/br_lite_traffic_port_pkg.sv
// Shared types for the BR-lite traffic port: NoC flit, queued service record, FSM encodings.
package BrLitePkg;
  localparam int ID_W      = 5;
  localparam int SRC_W     = 4;
  localparam int PAYLOAD_W = 32;

  typedef logic [ID_W-1:0] br_id_t;

  typedef struct packed {
    logic [SRC_W-1:0]     seq_source;
    logic                 clear;
    br_id_t               id;
    logic [PAYLOAD_W-1:0] payload;
  } br_data_t;

  typedef struct packed {
    logic [63:0]          timestamp;
    logic [PAYLOAD_W-1:0] payload;
  } br_svc_t;

  localparam logic       TX_IDLE  = 1'b0;
  localparam logic       TX_REQ   = 1'b1;
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_DELAY = 2'd1;
  localparam logic [1:0] RX_ACK   = 2'd2;
endpackage

// File: rtl/br_svc_fifo.sv
// Service FIFO; pointers carry an extra wrap bit so full and empty need no counter.
module br_svc_fifo
  import BrLitePkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  br_svc_t wdata,
  output br_svc_t rdata,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr, rptr;
  br_svc_t     mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

// File: rtl/br_lite_traffic_port.sv
// PE-side NoC port: timestamped service injection (TX) and delayed-ack delivery (RX).
module br_lite_traffic_port
  import BrLitePkg::*;
#(
  parameter logic [SRC_W-1:0] SOURCE    = '0,
  parameter int               SVC_DEPTH = 8,
  parameter int               ACK_DELAY = 2,
  parameter int               CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 svc_valid_i,
  output logic                 svc_ready_o,
  input  logic [63:0]          svc_timestamp_i,
  input  logic [PAYLOAD_W-1:0] svc_payload_i,
  input  logic                 enable_i,
  input  logic                 busy_i,
  output br_data_t             flit_o,
  output logic                 req_o,
  input  logic                 ack_i,
  input  br_data_t             flit_i,
  input  logic                 req_i,
  output logic                 ack_o,
  output logic                 rx_valid_o,
  output br_data_t             rx_flit_o,
  output logic [63:0]          tick_o,
  output logic [CNT_W-1:0]     sent_cnt_o,
  output logic [CNT_W-1:0]     recv_cnt_o,
  output logic                 idle_o
);
  if (SVC_DEPTH < 2 || (SVC_DEPTH & (SVC_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("SVC_DEPTH must be a power of two >= 2");
  end
  if (ACK_DELAY < 0 || ACK_DELAY > 7) begin : g_bad_delay
    $error("ACK_DELAY must be in 0..7");
  end

  logic       tx_state;
  logic [1:0] rx_state;
  logic [2:0] rx_cnt;
  br_id_t     id_q;
  br_svc_t    head;
  logic       fifo_full, fifo_empty, push, launch;

  br_svc_fifo #(.DEPTH(SVC_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .pop   (launch),
    .wdata ('{timestamp: svc_timestamp_i, payload: svc_payload_i}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Ready comes from registered pointers, so a pop cannot free a slot for a same-edge push.
  assign svc_ready_o = !fifo_full;
  assign push        = svc_valid_i && svc_ready_o;
  assign launch      = (tx_state == TX_IDLE) && !fifo_empty && enable_i && !busy_i &&
                       (head.timestamp <= tick_o);
  assign req_o       = (tx_state == TX_REQ);
  assign ack_o       = (rx_state == RX_ACK);
  assign idle_o      = fifo_empty && (tx_state == TX_IDLE) && (rx_state == RX_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tick_o <= '0;
    else         tick_o <= tick_o + 64'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state   <= TX_IDLE;
      flit_o     <= '0;
      id_q       <= '0;
      sent_cnt_o <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: if (launch) begin
          tx_state <= TX_REQ;
          flit_o   <= '{seq_source: SOURCE, clear: 1'b0, id: id_q, payload: head.payload};
          id_q     <= id_q + 1'b1;
        end
        default: if (ack_i) begin
          tx_state <= TX_IDLE;
          if (sent_cnt_o != '1) sent_cnt_o <= sent_cnt_o + 1'b1;
        end
      endcase
    end
  end

  // Leaving RX_ACK only on req_i low means a held request can never be captured twice.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_valid_o <= 1'b0;
      rx_flit_o  <= '0;
      recv_cnt_o <= '0;
    end else begin
      rx_valid_o <= 1'b0;
      case (rx_state)
        RX_IDLE: if (req_i) begin
          rx_flit_o  <= flit_i;
          rx_valid_o <= 1'b1;
          rx_cnt     <= 3'(ACK_DELAY);
          rx_state   <= (ACK_DELAY == 0) ? RX_ACK : RX_DELAY;
          if (recv_cnt_o != '1) recv_cnt_o <= recv_cnt_o + 1'b1;
        end
        RX_DELAY: begin
          rx_cnt <= rx_cnt - 3'd1;
          if (rx_cnt == 3'd1) rx_state <= RX_ACK;
        end
        RX_ACK: if (!req_i) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_br_lite_traffic_port.sv
// Directed bench: RX handshake vector table plus hand-written TX sequences.
module tb_br_lite_traffic_port;
  import BrLitePkg::*;

  localparam int DEPTH = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            svc_valid_i = 1'b0;
  logic            svc_ready_o;
  logic [63:0]     svc_timestamp_i = '0;
  logic [31:0]     svc_payload_i = '0;
  logic            enable_i = 1'b0;
  logic            busy_i = 1'b0;
  br_data_t        flit_o;
  logic            req_o;
  logic            ack_i = 1'b0;
  br_data_t        flit_i = '0;
  logic            req_i = 1'b0;
  logic            ack_o;
  logic            rx_valid_o;
  br_data_t        rx_flit_o;
  logic [63:0]     tick_o;
  logic [2:0]      sent_cnt_o;
  logic [2:0]      recv_cnt_o;
  logic            idle_o;

  br_lite_traffic_port #(.SOURCE(4'd5), .SVC_DEPTH(DEPTH), .ACK_DELAY(3), .CNT_W(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .svc_valid_i(svc_valid_i), .svc_ready_o(svc_ready_o),
    .svc_timestamp_i(svc_timestamp_i), .svc_payload_i(svc_payload_i), .enable_i(enable_i),
    .busy_i(busy_i), .flit_o(flit_o), .req_o(req_o), .ack_i(ack_i), .flit_i(flit_i),
    .req_i(req_i), .ack_o(ack_o), .rx_valid_o(rx_valid_o), .rx_flit_o(rx_flit_o),
    .tick_o(tick_o), .sent_cnt_o(sent_cnt_o), .recv_cnt_o(recv_cnt_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_sent = 0;
  logic [4:0] exp_id = '0;

  typedef struct {
    logic        req;
    logic [31:0] pl;
    logic        exp_rv;
    logic        exp_ack;
    logic [2:0]  exp_recv;
    logic [31:0] exp_flit;
  } rx_vec_t;
  rx_vec_t rxv [18];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [63:0] ts, input logic [31:0] pl);
    svc_valid_i = 1'b1;
    svc_timestamp_i = ts;
    svc_payload_i = pl;
    step();
    svc_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    step();
    rst_ni = 1'b1;
    exp_sent = 0;
    exp_id = '0;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!req_o && n < budget) begin
      step();
      n++;
    end
    chk("req_rise", 64'(req_o), 64'd1);
  endtask

  // Expects one flit with the given payload and the next id; acks after dly cycles.
  task automatic handshake(input logic [31:0] pl, input int dly);
    wait_req(40);
    chk("flit_id", 64'(flit_o.id), 64'(exp_id));
    chk("flit_payload", 64'(flit_o.payload), 64'(pl));
    chk("flit_src_clear", 64'({flit_o.seq_source, flit_o.clear}), 64'({4'd5, 1'b0}));
    for (int k = 0; k < dly; k++) begin
      step();
      chk("req_hold", 64'(req_o), 64'd1);
      chk("flit_stable", 64'(flit_o.payload), 64'(pl));
    end
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk("req_gap", 64'(req_o), 64'd0);
    exp_id = exp_id + 5'd1;
    if (exp_sent < 7) exp_sent++;
    chk("sent_cnt", 64'(sent_cnt_o), 64'(exp_sent));
  endtask

  initial begin
    // req_i held 10 cycles with ACK_DELAY=3, then a request that drops during the delay.
    rxv[0]  = '{1'b1, 32'hA000, 1'b1, 1'b0, 3'd1, 32'hA000};
    rxv[1]  = '{1'b1, 32'hA001, 1'b0, 1'b0, 3'd1, 32'hA000};
    rxv[2]  = '{1'b1, 32'hA002, 1'b0, 1'b0, 3'd1, 32'hA000};
    rxv[3]  = '{1'b1, 32'hA003, 1'b0, 1'b1, 3'd1, 32'hA000};
    rxv[4]  = '{1'b1, 32'hA004, 1'b0, 1'b1, 3'd1, 32'hA000};
    rxv[5]  = '{1'b1, 32'hA005, 1'b0, 1'b1, 3'd1, 32'hA000};
    rxv[6]  = '{1'b1, 32'hA006, 1'b0, 1'b1, 3'd1, 32'hA000};
    rxv[7]  = '{1'b1, 32'hA007, 1'b0, 1'b1, 3'd1, 32'hA000};
    rxv[8]  = '{1'b1, 32'hA008, 1'b0, 1'b1, 3'd1, 32'hA000};
    rxv[9]  = '{1'b1, 32'hA009, 1'b0, 1'b1, 3'd1, 32'hA000};
    rxv[10] = '{1'b0, 32'hA00A, 1'b0, 1'b0, 3'd1, 32'hA000};
    rxv[11] = '{1'b0, 32'hA00B, 1'b0, 1'b0, 3'd1, 32'hA000};
    rxv[12] = '{1'b1, 32'hA00C, 1'b1, 1'b0, 3'd2, 32'hA00C};
    rxv[13] = '{1'b0, 32'hA00D, 1'b0, 1'b0, 3'd2, 32'hA00C};
    rxv[14] = '{1'b0, 32'hA00E, 1'b0, 1'b0, 3'd2, 32'hA00C};
    rxv[15] = '{1'b0, 32'hA00F, 1'b0, 1'b1, 3'd2, 32'hA00C};
    rxv[16] = '{1'b0, 32'hA010, 1'b0, 1'b0, 3'd2, 32'hA00C};
    rxv[17] = '{1'b0, 32'hA011, 1'b0, 1'b0, 3'd2, 32'hA00C};

    // Reset state
    step();
    step();
    chk("rst_tick", tick_o, 64'd0);
    chk("rst_ready", 64'(svc_ready_o), 64'd1);
    chk("rst_req", 64'(req_o), 64'd0);
    chk("rst_flit", 64'(flit_o), 64'd0);
    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_rx", 64'({rx_valid_o, rx_flit_o}), 64'd0);
    chk("rst_cnts", 64'({sent_cnt_o, recv_cnt_o}), 64'd0);
    chk("rst_idle", 64'(idle_o), 64'd1);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("tick_count", tick_o, 64'd3);

    // RX vector table
    for (int i = 0; i < 18; i++) begin
      req_i = rxv[i].req;
      flit_i = '{seq_source: 4'd0, clear: 1'b0, id: 5'(i), payload: rxv[i].pl};
      step();
      chk($sformatf("rx_valid[%0d]", i), 64'(rx_valid_o), 64'(rxv[i].exp_rv));
      chk($sformatf("rx_ack[%0d]", i), 64'(ack_o), 64'(rxv[i].exp_ack));
      chk($sformatf("rx_recv[%0d]", i), 64'(recv_cnt_o), 64'(rxv[i].exp_recv));
      chk($sformatf("rx_flit[%0d]", i), 64'(rx_flit_o.payload), 64'(rxv[i].exp_flit));
    end

    // Three services, in order, ack two cycles after req
    push(64'd0, 32'h11);
    push(64'd5, 32'h22);
    push(64'd5, 32'h33);
    chk("no_inject_disabled", 64'(req_o), 64'd0);
    enable_i = 1'b1;
    handshake(32'h11, 2);
    handshake(32'h22, 2);
    handshake(32'h33, 2);
    step();
    chk("idle_after_tx", 64'(idle_o), 64'd1);

    // Late timestamp: ts=50 pushed at tick 10
    do_reset();
    for (int k = 0; k < 10; k++) step();
    chk("tick_at_push", tick_o, 64'd10);
    push(64'd50, 32'hC0);
    begin
      int n = 0;
      while (!req_o && n < 80) begin
        step();
        n++;
      end
    end
    chk("late_rise_tick", tick_o, 64'd51);
    handshake(32'hC0, 1);

    // Router busy blocks a due service
    busy_i = 1'b1;
    push(64'd0, 32'hD0);
    for (int k = 0; k < 20; k++) begin
      chk("busy_hold", 64'(req_o), 64'd0);
      step();
    end
    busy_i = 1'b0;
    step();
    chk("busy_release", 64'(req_o), 64'd1);
    handshake(32'hD0, 1);

    // Fill FIFO, then simultaneous pop and refused push on full
    enable_i = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      chk("ready_before_full", 64'(svc_ready_o), 64'd1);
      push(64'd0, 32'hE0 + 32'(k));
    end
    chk("ready_full", 64'(svc_ready_o), 64'd0);
    svc_valid_i = 1'b1;
    svc_payload_i = 32'hEFF;
    enable_i = 1'b1;
    step();
    svc_valid_i = 1'b0;
    for (int k = 0; k < DEPTH; k++) handshake(32'hE0 + 32'(k), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("no_extra_flit", 64'(req_o), 64'd0);
    end
    chk("idle_after_full", 64'(idle_o), 64'd1);

    // 33 injections wrap the id; counter saturates
    do_reset();
    for (int i = 0; i < 33; i++) begin
      push(64'd0, 32'hF00 + 32'(i));
      handshake(32'hF00 + 32'(i), 0);
    end
    chk("id_wrapped", 64'(exp_id), 64'd1);
    chk("sent_saturated", 64'(sent_cnt_o), 64'd7);

    // Reset during TX_REQ abandons transfer and queue
    enable_i = 1'b0;
    push(64'd0, 32'h77);
    push(64'd0, 32'h78);
    enable_i = 1'b1;
    wait_req(10);
    chk("mid_flit_id", 64'(flit_o.id), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_req", 64'(req_o), 64'd0);
    chk("rst_mid_ready", 64'(svc_ready_o), 64'd1);
    chk("rst_mid_idle", 64'(idle_o), 64'd1);
    chk("rst_mid_flit", 64'(flit_o), 64'd0);
    step();
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("queue_discarded", 64'(req_o), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/br_lite_traffic_port.md
BR_LITE_TRAFFIC_PORT -- requirements
Module: br_lite_traffic_port

Interface
REQ-001 Parameter SOURCE, default 0: address written into seq_source of every injected flit.
REQ-002 Parameter SVC_DEPTH, default 8: service FIFO depth, power of two, >= 2.
REQ-003 Parameter ACK_DELAY, default 2: cycles from req_i capture to ack_o assertion, range 0..7.
REQ-004 Parameter CNT_W, default 16: width of statistics counters.
REQ-005 Clock and reset: clk_i input 1, rising-edge clock; rst_ni input 1, reset. One clock; reset is asynchronous and active-low.
REQ-006 svc_valid_i input 1: service push request; svc_ready_o output 1: FIFO not full.
REQ-007 svc_timestamp_i input 64: earliest tick for injection; svc_payload_i input payload width of br_data_t: flit payload.
REQ-008 enable_i input 1: injection enable; busy_i input 1: router busy for this PE.
REQ-009 flit_o output br_data_t, req_o output 1, ack_i input 1: injection handshake toward the NoC.
REQ-010 flit_i input br_data_t, req_i input 1, ack_o output 1: delivery handshake from the NoC.
REQ-011 rx_valid_o output 1 and rx_flit_o output br_data_t: one-cycle capture pulse and the captured flit.
REQ-012 tick_o output 64, sent_cnt_o output CNT_W, recv_cnt_o output CNT_W, idle_o output 1: FIFO empty, TX idle, RX idle.

Function
REQ-013 tick_o increments by 1 every cycle after reset; wraps at 2^64.
REQ-014 Push occurs when svc_valid_i and svc_ready_o are both high; a push into a full FIFO is ignored, with no state change.
REQ-015 TX FSM states: TX_IDLE, TX_REQ.
REQ-016 TX_IDLE to TX_REQ when FIFO non-empty, enable_i=1, busy_i=0, and head timestamp <= tick_o (unsigned compare); same edge pops the head and registers flit_o.
REQ-017 flit_o fields: seq_source=SOURCE, payload=head payload, clear=0, id=internal id counter.
REQ-018 id counter increments once per injection, width of br_data_t id; 31 wraps to 0.
REQ-019 req_o=1 exactly in TX_REQ; flit_o stays stable while req_o=1.
REQ-020 TX_REQ to TX_IDLE on the first edge with ack_i=1; sent_cnt_o increments on that edge.
REQ-021 Back-to-back injection: at least one TX_IDLE cycle with req_o=0 between flits.
REQ-022 Services inject strictly in FIFO order; a late head blocks younger services (no reordering).
REQ-023 RX FSM states: RX_IDLE, RX_DELAY, RX_ACK.
REQ-024 In RX_IDLE with req_i=1: register flit_i into rx_flit_o, pulse rx_valid_o for one cycle, and increment recv_cnt_o. Go to RX_DELAY loaded with ACK_DELAY, or to RX_ACK if ACK_DELAY=0.
REQ-025 RX_DELAY decrements each cycle and goes to RX_ACK on the edge where the count reaches 1.
REQ-026 ack_o=1 exactly in RX_ACK; RX_ACK to RX_IDLE on the first edge with req_i=0.
REQ-027 A new capture requires req_i to be seen low first; a req_i held high never captures twice.
REQ-028 sent_cnt_o and recv_cnt_o saturate at all-ones.
REQ-029 TX and RX operate independently; a push, a pop, and an RX capture can all occur on the same edge.
REQ-030 Simultaneous push and pop on a full FIFO: the pop happens and the push is refused, because svc_ready_o is registered from the pre-edge state.
REQ-031 enable_i=0 stops only new injections; an in-flight TX_REQ completes normally.

Reset
REQ-032 While rst_ni=0, asynchronously: tick_o=0, FIFO empty, svc_ready_o=1, req_o=0, flit_o='0, id=0, ack_o=0, rx_valid_o=0, rx_flit_o='0, both counters=0, idle_o=1, and both FSMs in their IDLE states.
REQ-033 Reset mid-handshake abandons the transfer: req_o and ack_o drop immediately, and queued services are discarded.

Structure
REQ-034 br_data_t, the id width, and a new br_svc_t typedef (timestamp, payload) live in BrLitePkg.
REQ-035 SVC_DEPTH and ACK_DELAY are checked in elaboration-time assertions, not in the package.
REQ-036 The FIFO is a sub-module, br_svc_fifo: parametrised on depth, carries br_svc_t, with asynchronous active-low reset and full/empty flags from read/write pointers one bit wider than the address.

Verification
REQ-037 Push 3 services (ts 0, 5, 5), ack_i returned 2 cycles after req_o -> 3 flits, ids 0, 1, 2, in order; sent_cnt_o=3.
REQ-038 Push ts=50 at tick 10 -> req_o rises no earlier than the edge after tick_o reaches 50.
REQ-039 busy_i=1 for 20 cycles with a due service -> req_o stays 0 throughout, then rises within 1 cycle of busy_i falling.
REQ-040 Push SVC_DEPTH+1 services with enable_i=0 -> svc_ready_o=0 after SVC_DEPTH pushes and the extra push is dropped; after enable, exactly SVC_DEPTH flits are sent.
REQ-041 ACK_DELAY=3, req_i held 10 cycles -> one rx_valid_o pulse, ack_o rises 3 cycles after capture and stays high until req_i falls; recv_cnt_o=1.
REQ-042 33 injections -> the 33rd flit has id 0; rst_ni pulsed during TX_REQ -> req_o=0 at once and the FIFO is empty.
